// File: rtl/ufifo_wr_arbiter_pkg.sv
// ufifo_wr_arbiter_pkg: FSM state type and width helpers shared by the arbiter files
package ufifo_wr_arbiter_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic int cred_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction
  function automatic int own_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int burst_w(input int b);
    return $clog2(b + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request searching upward from ptr_i, wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  logic [W:0]   s;
  logic [W-1:0] j;
  // walk offsets downward so the smallest offset from ptr_i wins
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    s = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr_i} + (W + 1)'(k);
      j = s >= (W + 1)'(N) ? W'(s - (W + 1)'(N)) : s[W-1:0];
      if (req_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/ufifo_wr_arbiter.sv
// ufifo_wr_arbiter: credit-based round-robin burst arbiter feeding a shared micro FIFO write port
module ufifo_wr_arbiter
  import ufifo_wr_arbiter_pkg::*;
#(
  parameter int lpm_width = 8,
  parameter int lpm_depth = 2,
  parameter int num_req   = 4,
  parameter int burst_max = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_req-1:0]             req,
  input  logic [num_req*lpm_width-1:0]   req_data,
  output logic [num_req-1:0]             ack,
  output logic [lpm_width-1:0]           d,
  output logic                           denable,
  input  logic                           credit_ret,
  output logic [cred_w(lpm_depth)-1:0]   credits,
  output logic [own_w(num_req)-1:0]      owner,
  output logic                           busy,
  output logic                           cred_err
);
  localparam int CW = cred_w(lpm_depth);
  localparam int OW = own_w(num_req);
  localparam int BW = burst_w(burst_max);
  localparam logic [CW-1:0] CAP = CW'(2 * lpm_depth);

  state_e                 state_q, state_d;
  logic [OW-1:0]          rr_q, rr_d, owner_q, owner_d, pick_idx;
  logic [BW-1:0]          burst_q, burst_d;
  logic [CW-1:0]          cred_q, cred_d;
  logic [lpm_width-1:0]   d_q, d_d;
  logic                   den_q, err_q, err_d, pick_v, accept, last;

  rr_pick #(.N(num_req), .W(OW)) u_rr_pick (
    .req_i  (req),
    .ptr_i  (rr_q),
    .valid_o(pick_v),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      burst_q <= '0;
      cred_q  <= CAP;
      d_q     <= '0;
      den_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      cred_q  <= cred_d;
      d_q     <= d_d;
      den_q   <= accept;
      err_q   <= err_d;
    end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    rr_d = rr_q;
    last = burst_q == BW'(burst_max - 1);
    if (!busy) begin
      if (pick_v) begin
        state_d = GRANT;
        owner_d = pick_idx;
        burst_d = '0;
      end
    end else if (!req[owner_q] || (accept && last)) begin
      state_d = IDLE;
      rr_d = owner_q == OW'(num_req - 1) ? '0 : owner_q + 1'b1;
    end else if (accept) begin
      burst_d = burst_q + 1'b1;
    end
    // a return at full count is bogus: hold the count and flag it
    cred_d = accept == credit_ret ? cred_q :
             accept ? cred_q - 1'b1 :
             cred_q == CAP ? CAP : cred_q + 1'b1;
    err_d = err_q | (credit_ret && cred_q == CAP);
    d_d = accept ? req_data[owner_q*lpm_width +: lpm_width] : d_q;
  end

  always_comb begin
    busy = state_q == GRANT;
    accept = busy && req[owner_q] && cred_q != '0;
    ack = accept ? {{(num_req - 1){1'b0}}, 1'b1} << owner_q : '0;
  end

  assign d        = d_q;
  assign denable  = den_q;
  assign credits  = cred_q;
  assign owner    = owner_q;
  assign cred_err = err_q;
endmodule

// File: doc/ufifo_wr_arbiter.md
UFIFO_WR_ARBITER -- requirements
Module: ufifo_wr_arbiter

Interface
REQ-001 Parameter lpm_width, default 8, data word width, identical to the shared micro FIFO.
REQ-002 Parameter lpm_depth, default 2, micro FIFO depth; the FIFO holds 2*lpm_depth cells, which is also the credit capacity.
REQ-003 Parameter num_req, default 4, number of requesters, legal range 2..16.
REQ-004 Parameter burst_max, default 4, maximum words per grant, legal range 1..255.
REQ-005 clk  input  1  the single clock of the block.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  num_req  per-requester request; a requester holds its bit high while it has a word on its data slice.
REQ-008 req_data  input  num_req*lpm_width  requester data; slice i is bits [i*lpm_width +: lpm_width].
REQ-009 ack  output  num_req  one-hot pulse marking that the word of requester i is accepted this cycle.
REQ-010 d  output  lpm_width  registered word to the FIFO write port.
REQ-011 denable  output  1  registered write strobe to the FIFO.
REQ-012 credit_ret  input  1  single-cycle pulse meaning one FIFO cell has been freed; it arrives already synchronized to clk.
REQ-013 credits  output  clog2(2*lpm_depth+1)  current free-cell count.
REQ-014 owner  output  clog2(num_req)  index of the current grant holder; valid while busy is high.
REQ-015 busy  output  1  high in state GRANT.
REQ-016 cred_err  output  1  sticky flag set when credit_ret arrives while credits equal 2*lpm_depth.

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-018 In IDLE with any req bit high, the block SHALL pick the first set bit found searching upward from rr_ptr, wrapping modulo num_req.
REQ-019 On that pick, the block SHALL load owner, clear the burst counter, and enter GRANT on the next cycle; no word is accepted in IDLE.
REQ-020 In IDLE with req all zero, the block SHALL remain in IDLE.
REQ-021 In GRANT, an accept SHALL occur when req[owner]=1 and credits>0.
REQ-022 On an accept, ack[owner]=1 in the same cycle, combinationally.
REQ-023 One cycle after an accept, d SHALL equal that requester's data slice and denable=1; otherwise denable=0 and d holds its value.
REQ-024 While credits=0 and req[owner]=1, the block SHALL stall in GRANT with ack=0, without releasing and without a timeout.
REQ-025 The block SHALL release to IDLE after an accept that brings the burst count to burst_max.
REQ-026 The block SHALL also release to IDLE in any GRANT cycle where req[owner]=0.
REQ-027 On either release, rr_ptr SHALL become (owner+1) mod num_req.
REQ-028 Credits SHALL decrement by 1 on an accept and increment by 1 on credit_ret; when both occur in the same cycle, credits SHALL be unchanged.
REQ-029 When credit_ret arrives at credits=2*lpm_depth, credits SHALL saturate and cred_err SHALL be set.
REQ-030 The block SHALL never produce an accept at credits=0.
REQ-031 ack SHALL be zero for every requester other than owner.
REQ-032 Requests that change while another requester holds the grant SHALL have no effect until the next IDLE.

Reset
REQ-033 Asserting reset at any time, including mid-burst, SHALL asynchronously force: state=IDLE, rr_ptr=0, owner=0, burst counter=0, d=0, denable=0, credits=2*lpm_depth, cred_err=0.
REQ-034 While reset is high, busy=0 and ack=0.
REQ-035 Reset SHALL be applied together with the FIFO's reset so that the credit count matches an empty FIFO.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE, GRANT) and the width helpers for credits, owner and the burst counter.
REQ-037 The round-robin search SHALL live in one sub-module, rr_pick, which takes req and rr_ptr and returns a valid flag and an index.
REQ-038 The block SHALL be instantiated beside the write side of the FIFO, with the FIFO's write clock as clk.

Verification
REQ-039 Reset, then req=4'b0001 with data 0x11, 0x12, 0x13 and credits=4 → ack[0] on three consecutive cycles starting 1 cycle after req; d/denable one cycle after each ack; credits=1.
REQ-040 req=4'b1111 held, burst_max=4, ample credit_ret → grant order 0,1,2,3,0; each grant carries 4 acks; exactly 1 IDLE cycle between grants.
REQ-041 Credits exhausted (4 accepts, no returns) with req[2] still high → ack=0 and busy=1 held; a single credit_ret → exactly one ack on the following cycle.
REQ-042 credit_ret and an accept in the same cycle at credits=2 → credits stays 2; credit_ret at credits=4 → cred_err=1, credits stays 4.
REQ-043 req[3] dropped after 2 words → release, rr_ptr=0; req=4'b1001 next → grant goes to requester 0.
REQ-044 reset asserted mid-burst at owner=1 → same-cycle denable=0, ack=0, credits=4, state IDLE.
